// File: rtl/pulse_sequencer.sv
// pulse_sequencer: steps the pulse generator through a table of timing sets; define PULSE_SEQ_LOOP_EN to repeat the table until stopped
module pulse_sequencer #(
   parameter int DEPTH_LOG2 = 3,
   parameter int SHOT_W = 16
) (
   input  logic                  clk_pll,
   input  logic                  reset,
   input  logic [31:0]           period,
   input  logic                  start,
   input  logic                  stop,
   input  logic [DEPTH_LOG2-1:0] num_steps,
   input  logic [SHOT_W-1:0]     shots,
   input  logic                  tbl_we,
   input  logic [DEPTH_LOG2-1:0] tbl_addr,
   input  logic [1:0]            tbl_sel,
   input  logic [31:0]           tbl_data,
   output logic                  run,
   output logic [31:0]           p1width,
   output logic [31:0]           p2start,
   output logic [31:0]           delay,
   output logic [DEPTH_LOG2-1:0] step,
   output logic [SHOT_W-1:0]     shot_cnt,
   output logic                  frame_start,
   output logic                  busy,
   output logic                  done
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef PULSE_SEQ_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   state_t state;
   logic [31:0] tbl_p1 [DEPTH];
   logic [31:0] tbl_p2 [DEPTH];
   logic [31:0] tbl_dl [DEPTH];
   logic [DEPTH_LOG2-1:0] last_step, next_step;
   logic [SHOT_W-1:0] shots_max;
   logic [31:0] fcnt;
   logic stop_pend, frame_end, stop_now, step_end, seq_end, finish;

   assign frame_end = fcnt == period;
   assign stop_now = stop_pend | stop;
   assign step_end = shot_cnt + SHOT_W'(1) == shots_max;
   assign seq_end = step_end && step == last_step;
   assign finish = seq_end && !LOOP;
   assign next_step = seq_end ? '0 : step + DEPTH_LOG2'(1);

   // table writes land in every state; outputs only see them at load points
   always_ff @(posedge clk_pll or posedge reset)
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_p1[i] <= '0;
            tbl_p2[i] <= '0;
            tbl_dl[i] <= '0;
         end
      end else if (tbl_we) begin
         if (tbl_sel == 2'd0) tbl_p1[tbl_addr] <= tbl_data;
         if (tbl_sel == 2'd1) tbl_p2[tbl_addr] <= tbl_data;
         if (tbl_sel == 2'd2) tbl_dl[tbl_addr] <= tbl_data;
      end

   // run-level FSM: frame counter, shot/step bookkeeping and registered outputs
   always_ff @(posedge clk_pll or posedge reset)
      if (reset) begin
         state       <= IDLE;
         run         <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         frame_start <= 1'b0;
         p1width     <= '0;
         p2start     <= '0;
         delay       <= '0;
         step        <= '0;
         shot_cnt    <= '0;
         last_step   <= '0;
         shots_max   <= '0;
         fcnt        <= '0;
         stop_pend   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE:
               if (start) begin
                  state     <= LOAD;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  last_step <= num_steps;
                  shots_max <= (shots == '0) ? SHOT_W'(1) : shots;
                  step      <= '0;
                  shot_cnt  <= '0;
               end
            LOAD: begin
               state       <= RUN;
               run         <= 1'b1;
               frame_start <= 1'b1;
               fcnt        <= '0;
               stop_pend   <= 1'b0;
               p1width     <= tbl_p1[step];
               p2start     <= tbl_p2[step];
               delay       <= tbl_dl[step];
            end
            RUN:
               if (!frame_end) begin
                  fcnt        <= fcnt + 32'd1;
                  frame_start <= 1'b0;
                  stop_pend   <= stop_now;
               end else begin
                  fcnt        <= '0;
                  frame_start <= !(stop_now || finish);
                  if (stop_now) begin
                     state     <= IDLE;
                     run       <= 1'b0;
                     busy      <= 1'b0;
                     stop_pend <= 1'b0;
                  end else if (finish) begin
                     state <= DONE;
                     run   <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else if (step_end) begin
                     step     <= next_step;
                     shot_cnt <= '0;
                     p1width  <= tbl_p1[next_step];
                     p2start  <= tbl_p2[next_step];
                     delay    <= tbl_dl[next_step];
                  end else
                     shot_cnt <= shot_cnt + SHOT_W'(1);
               end
            default: state <= IDLE;
         endcase
      end
endmodule
